// File: rtl/strip_pkg.sv
// Shared constants and FSM state type for the vertical strip loader.
// Holds the global image geometry (WIDTH, LENGTH) and derived strip counts.
package strip_pkg;

  // Global image geometry: rows per strip and columns per strip.
  localparam int STRIP_WIDTH      = 28;
  localparam int STRIP_LENGTH     = 4;

  // Image width and number of strips it splits into.
  localparam int STRIP_IMG_COLS   = 28;
  localparam int STRIP_NUM_STRIPS = STRIP_IMG_COLS / STRIP_LENGTH;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/strip_frame_store.sv
// Binary frame store with one pixel write port and a strip read port.
// Ports: clk, we/wr_row/wr_col/wr_data (write), rd_k -> rd_strip (strip k).
module strip_frame_store
  import strip_pkg::*;
#(
  parameter int WIDTH    = STRIP_WIDTH,
  parameter int LENGTH   = STRIP_LENGTH,
  parameter int IMG_COLS = STRIP_IMG_COLS,
  localparam int NUM_STRIPS = IMG_COLS / LENGTH,
  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1,
  localparam int KW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [RW-1:0]             wr_row,
  input  logic [CW-1:0]             wr_col,
  input  logic                      wr_data,
  input  logic [KW-1:0]             rd_k,
  output logic [WIDTH*LENGTH-1:0]   rd_strip
);

  logic [IMG_COLS-1:0] mem_q [WIDTH];
  logic [CW-1:0]       col;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_row][wr_col] <= wr_data;
    end
  end

  // Strip bit r*LENGTH+c comes from column k*LENGTH+c of row r.
  always_comb begin
    rd_strip = '0;
    col      = '0;
    for (int r = 0; r < WIDTH; r++) begin
      for (int c = 0; c < LENGTH; c++) begin
        col = CW'(int'(rd_k) * LENGTH + c);
        rd_strip[r*LENGTH+c] = mem_q[r][col];
      end
    end
  end

endmodule

// File: rtl/vertical_strip_loader.sv
// Loads a raster binary frame, then emits it as NUM_STRIPS column strips.
// Ports: clk, rst, pix_* (valid/ready pixel in), strip_* (valid/ready out),
//        frame_err (one-cycle framing error pulse).
module vertical_strip_loader
  import strip_pkg::*;
#(
  parameter int WIDTH    = STRIP_WIDTH,
  parameter int LENGTH   = STRIP_LENGTH,
  parameter int IMG_COLS = STRIP_IMG_COLS,
  localparam int NUM_STRIPS = IMG_COLS / LENGTH,
  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1,
  localparam int KW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    pix_data,
  input  logic                    pix_last,
  output logic                    strip_valid,
  input  logic                    strip_ready,
  output logic [WIDTH*LENGTH-1:0] strip,
  output logic [KW-1:0]           strip_idx,
  output logic                    strip_last,
  output logic                    frame_err
);

  localparam logic [RW-1:0] ROW_MAX = RW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_COLS - 1);
  localparam logic [KW-1:0] K_MAX   = KW'(NUM_STRIPS - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic          frame_err_q, frame_err_d;

  logic                    pix_acc;
  logic                    at_final;
  logic                    emit;
  logic [WIDTH*LENGTH-1:0] rd_strip;

  assign pix_ready = (state_q == ST_LOAD);
  assign pix_acc   = pix_valid && pix_ready;
  assign at_final  = (row_cnt_q == ROW_MAX) &&
                     (col_cnt_q == COL_MAX);

  // Outputs are forced quiet while reset is held.
  assign emit        = (state_q == ST_EMIT) && !rst;
  assign strip_valid = emit;
  assign strip       = emit ? rd_strip : '0;
  assign strip_idx   = emit ? k_q : '0;
  assign strip_last  = emit && (k_q == K_MAX);
  assign frame_err   = frame_err_q;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    k_d         = k_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (pix_acc) begin
          if (at_final) begin
            row_cnt_d = '0;
            col_cnt_d = '0;
            if (pix_last) begin
              state_d = ST_EMIT;
              k_d     = '0;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (pix_last) begin
            // Early end of frame: drop it and resync.
            row_cnt_d   = '0;
            col_cnt_d   = '0;
            frame_err_d = 1'b1;
          end else if (col_cnt_q == COL_MAX) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + RW'(1);
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
          end
        end
      end
      ST_EMIT: begin
        if (strip_ready) begin
          if (k_q == K_MAX) begin
            state_d   = ST_LOAD;
            k_d       = '0;
            row_cnt_d = '0;
            col_cnt_d = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      k_q         <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      k_q         <= k_d;
      frame_err_q <= frame_err_d;
    end
  end

  strip_frame_store #(
    .WIDTH    (WIDTH),
    .LENGTH   (LENGTH),
    .IMG_COLS (IMG_COLS)
  ) u_store (
    .clk      (clk),
    .we       (pix_acc),
    .wr_row   (row_cnt_q),
    .wr_col   (col_cnt_q),
    .wr_data  (pix_data),
    .rd_k     (k_q),
    .rd_strip (rd_strip)
  );

endmodule

// File: tb/tb_vertical_strip_loader.sv
// Testbench for vertical_strip_loader: random frames vs an image model.
// Scenarios cover reset, strip content, stalls, framing errors, back-to-back.
module tb_vertical_strip_loader;

  localparam int W    = 28;
  localparam int L    = 4;
  localparam int C    = 28;
  localparam int NS   = C / L;
  localparam int NPIX = W * C;
  localparam int SW   = W * L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix_data = 1'b0;
  logic          pix_last = 1'b0;
  logic          strip_ready = 1'b0;
  logic          pix_ready;
  logic          strip_valid;
  logic [SW-1:0] strip;
  logic [2:0]    strip_idx;
  logic          strip_last;
  logic          frame_err;

  vertical_strip_loader #(
    .WIDTH    (W),
    .LENGTH   (L),
    .IMG_COLS (C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .strip_valid (strip_valid),
    .strip_ready (strip_ready),
    .strip       (strip),
    .strip_idx   (strip_idx),
    .strip_last  (strip_last),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int timeouts = 0;

  // Reference images: imgs[f][row][col].
  bit [C-1:0] imgs [2][W];

  int err_cnt = 0;
  int sv_cnt = 0;
  int prdy_low_cnt = 0;

  logic [SW-1:0] q_strip [$];
  int            q_idx [$];
  logic          q_last [$];
  logic [SW-1:0] st_strip [$];
  int            st_idx [$];
  logic          st_valid [$];

  always @(posedge clk) begin
    #2;
    if (frame_err === 1'b1) err_cnt++;
    if (strip_valid === 1'b1) sv_cnt++;
    if (pix_ready !== 1'b1) prdy_low_cnt++;
  end

  function automatic logic [SW-1:0] exp_strip(int f, int k);
    logic [SW-1:0] s;
    s = '0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < L; c++)
        s[r*L+c] = imgs[f][r][k*L+c];
    return s;
  endfunction

  task automatic rand_img(input int f);
    for (int r = 0; r < W; r++) imgs[f][r] = C'($urandom);
  endtask

  task automatic clr_cnt();
    err_cnt = 0;
    sv_cnt = 0;
    prdy_low_cnt = 0;
    timeouts = 0;
  endtask

  task automatic drive_frame(input int f, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = imgs[f][i/C][i%C];
      pix_last  = (i == last_at);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    pix_data  = 1'b0;
  endtask

  // Accepts strips; optionally holds off at stall_k for stall_n cycles,
  // or stops (without accepting) when stop_k is displayed.
  task automatic collect(input int stall_k, input int stall_n,
                         input int stop_k);
    int  left;
    bit  done;
    left = stall_n;
    done = 1'b0;
    q_strip.delete(); q_idx.delete(); q_last.delete();
    st_strip.delete(); st_idx.delete(); st_valid.delete();
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      strip_ready = 1'b0;
      if (left > 0 && (left < stall_n ||
          (strip_valid === 1'b1 && int'(strip_idx) == stall_k))) begin
        st_strip.push_back(strip);
        st_idx.push_back(int'(strip_idx));
        st_valid.push_back(strip_valid);
        left--;
      end else if (strip_valid === 1'b1) begin
        if (stop_k >= 0 && int'(strip_idx) == stop_k) begin
          done = 1'b1;
        end else begin
          strip_ready = 1'b1;
          q_strip.push_back(strip);
          q_idx.push_back(int'(strip_idx));
          q_last.push_back(strip_last);
          if (strip_last === 1'b1) done = 1'b1;
        end
      end
    end
    if (!done) timeouts++;
    @(negedge clk);
    strip_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (strip_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_strip_valid: got %b want 0", strip_valid);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_frame_err: got %b want 0", frame_err);
    end
    vectors++;
    if (strip_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_strip_idx: got %0d want 0", strip_idx);
    end
    vectors++;
    if (strip_last !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_strip_last: got %b want 0", strip_last);
    end
    vectors++;
    if (strip !== '0) begin
      miscompares++;
      $display("FAIL rst_strip: got %h want 0", strip);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (pix_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pix_ready: got %b want 1", pix_ready);
    end
  endtask

  task automatic test_single_column();
    logic [SW-1:0] col1;
    col1 = '0;
    for (int r = 0; r < W; r++) begin
      imgs[0][r] = '0;
      imgs[0][r][5] = 1'b1;
      col1[r*L+1] = 1'b1;
    end
    clr_cnt();
    drive_frame(0, NPIX, NPIX - 1);
    collect(-1, 0, -1);
    vectors++;
    if (timeouts != 0 || q_strip.size() != NS) begin
      miscompares++;
      $display("FAIL col5_count: got %0d strips want %0d",
               q_strip.size(), NS);
    end
    for (int i = 0; i < q_strip.size(); i++) begin
      vectors++;
      if (q_idx[i] != i || q_strip[i] !== exp_strip(0, i) ||
          q_last[i] !== (i == NS - 1)) begin
        miscompares++;
        $display("FAIL col5_strip%0d: got idx %0d last %b %h want %h",
                 i, q_idx[i], q_last[i], q_strip[i], exp_strip(0, i));
      end
    end
    if (q_strip.size() > 1) begin
      vectors++;
      if (q_strip[1] !== col1) begin
        miscompares++;
        $display("FAIL col5_s1: got %h want %h", q_strip[1], col1);
      end
    end
    vectors++;
    if (err_cnt != 0) begin
      miscompares++;
      $display("FAIL col5_err: got %0d pulses want 0", err_cnt);
    end
  endtask

  task automatic test_stall();
    rand_img(0);
    clr_cnt();
    drive_frame(0, NPIX, NPIX - 1);
    collect(3, 10, -1);
    vectors++;
    if (st_strip.size() != 10) begin
      miscompares++;
      $display("FAIL stall_len: got %0d want 10", st_strip.size());
    end
    for (int i = 0; i < st_strip.size(); i++) begin
      vectors++;
      if (st_idx[i] != 3 || st_valid[i] !== 1'b1 ||
          st_strip[i] !== exp_strip(0, 3)) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got idx %0d v %b %h want 3 1 %h",
                 i, st_idx[i], st_valid[i], st_strip[i],
                 exp_strip(0, 3));
      end
    end
    vectors++;
    if (timeouts != 0 || q_strip.size() != NS) begin
      miscompares++;
      $display("FAIL stall_count: got %0d want %0d",
               q_strip.size(), NS);
    end
    for (int i = 0; i < q_strip.size(); i++) begin
      vectors++;
      if (q_idx[i] != i || q_strip[i] !== exp_strip(0, i)) begin
        miscompares++;
        $display("FAIL stall_strip%0d: got idx %0d %h want %h",
                 i, q_idx[i], q_strip[i], exp_strip(0, i));
      end
    end
  endtask

  task automatic test_early_last();
    rand_img(0);
    clr_cnt();
    drive_frame(0, 101, 100);
    repeat (5) @(negedge clk);
    vectors++;
    if (err_cnt != 1 || sv_cnt != 0) begin
      miscompares++;
      $display("FAIL early_err: got err %0d sv %0d want 1 0",
               err_cnt, sv_cnt);
    end
    rand_img(0);
    drive_frame(0, NPIX, NPIX - 1);
    collect(-1, 0, -1);
    vectors++;
    if (timeouts != 0 || q_strip.size() != NS) begin
      miscompares++;
      $display("FAIL early_next: got %0d strips want %0d",
               q_strip.size(), NS);
    end
    for (int i = 0; i < q_strip.size(); i++) begin
      vectors++;
      if (q_idx[i] != i || q_strip[i] !== exp_strip(0, i)) begin
        miscompares++;
        $display("FAIL early_strip%0d: got idx %0d %h want %h",
                 i, q_idx[i], q_strip[i], exp_strip(0, i));
      end
    end
  endtask

  task automatic test_missing_last();
    rand_img(0);
    clr_cnt();
    drive_frame(0, NPIX, -1);
    repeat (5) @(negedge clk);
    vectors++;
    if (err_cnt != 1 || sv_cnt != 0 || prdy_low_cnt != 0) begin
      miscompares++;
      $display("FAIL nolast: got err %0d sv %0d rdylow %0d want 1 0 0",
               err_cnt, sv_cnt, prdy_low_cnt);
    end
  endtask

  task automatic test_reset_during_emit();
    rand_img(0);
    clr_cnt();
    drive_frame(0, NPIX, NPIX - 1);
    collect(-1, 0, 4);
    vectors++;
    if (q_strip.size() != 4) begin
      miscompares++;
      $display("FAIL rstemit_pre: got %0d strips want 4",
               q_strip.size());
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (strip_valid !== 1'b0 || pix_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstemit_now: got sv %b rdy %b want 0 1",
               strip_valid, pix_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (strip_valid !== 1'b0 || pix_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstemit_after: got sv %b rdy %b want 0 1",
               strip_valid, pix_ready);
    end
    rand_img(0);
    clr_cnt();
    drive_frame(0, NPIX, NPIX - 1);
    collect(-1, 0, -1);
    vectors++;
    if (timeouts != 0 || q_strip.size() != NS) begin
      miscompares++;
      $display("FAIL rstemit_count: got %0d want %0d",
               q_strip.size(), NS);
    end
    for (int i = 0; i < q_strip.size(); i++) begin
      vectors++;
      if (q_idx[i] != i || q_strip[i] !== exp_strip(0, i)) begin
        miscompares++;
        $display("FAIL rstemit_strip%0d: got idx %0d %h want %h",
                 i, q_idx[i], q_strip[i], exp_strip(0, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int low_between;
    int f;
    int i;
    rand_img(0);
    rand_img(1);
    clr_cnt();
    q_strip.delete(); q_idx.delete(); q_last.delete();
    p = 0;
    low_between = 0;
    strip_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 &&
         (p < 2 * NPIX || q_strip.size() < 2 * NS); cyc++) begin
      @(negedge clk);
      if (strip_valid === 1'b1) begin
        q_strip.push_back(strip);
        q_idx.push_back(int'(strip_idx));
        q_last.push_back(strip_last);
      end
      if (pix_ready === 1'b1 && p < 2 * NPIX) begin
        f = p / NPIX;
        i = p % NPIX;
        pix_valid = 1'b1;
        pix_data  = imgs[f][i/C][i%C];
        pix_last  = (i == NPIX - 1);
        p++;
      end else if (pix_ready === 1'b1) begin
        pix_valid = 1'b0;
        pix_last  = 1'b0;
      end else if (p == NPIX) begin
        low_between++;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last = 1'b0;
    strip_ready = 1'b0;
    vectors++;
    if (low_between != NS) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d rdy-low cycles want %0d",
               low_between, NS);
    end
    vectors++;
    if (q_strip.size() != 2 * NS) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want %0d",
               q_strip.size(), 2 * NS);
    end
    for (int j = 0; j < q_strip.size() && j < 2 * NS; j++) begin
      vectors++;
      if (q_idx[j] != j % NS ||
          q_strip[j] !== exp_strip(j / NS, j % NS)) begin
        miscompares++;
        $display("FAIL b2b_strip%0d: got idx %0d %h want %h",
                 j, q_idx[j], q_strip[j], exp_strip(j / NS, j % NS));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_column();
    test_stall();
    test_early_last();
    test_missing_last();
    test_reset_during_emit();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/vertical_strip_loader.md
VERTICAL_STRIP_LOADER -- requirements
Module: vertical_strip_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 28, rows per strip (the image height).
REQ-002 SHALL have parameter LENGTH, default 4, columns per strip.
REQ-003 SHALL have parameter IMG_COLS, default 28, image width in pixels; must be a multiple of LENGTH.
REQ-004 SHALL derive NUM_STRIPS = IMG_COLS/LENGTH (default 7).
REQ-005 SHALL provide port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL provide port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL provide port pix_valid, input, 1: pixel offered.
REQ-008 SHALL provide port pix_ready, output, 1: pixel accepted when pix_valid and pix_ready are both high.
REQ-009 SHALL provide port pix_data, input, 1: binarized pixel, sent in raster order (row-major, column 0 first).
REQ-010 SHALL provide port pix_last, input, 1: marks the final pixel of a frame.
REQ-011 SHALL provide port strip_valid, output, 1: strip offered.
REQ-012 SHALL provide port strip_ready, input, 1: consumer (the transition counter) accepts the strip.
REQ-013 SHALL provide port strip, output, WIDTH*LENGTH: bit r*LENGTH+c = pixel(row r, column k*LENGTH+c) for strip k.
REQ-014 SHALL provide port strip_idx, output, $clog2(NUM_STRIPS): current strip index k.
REQ-015 SHALL provide port strip_last, output, 1: high while k = NUM_STRIPS-1.
REQ-016 SHALL provide port frame_err, output, 1: one-cycle pulse on a framing error.

Function
REQ-017 SHALL implement a two-state FSM: LOAD and EMIT.
REQ-018 In LOAD, SHALL drive pix_ready=1 and strip_valid=0.
REQ-019 In LOAD, SHALL write each accepted pixel into the WIDTH x IMG_COLS frame store at (row_cnt, col_cnt).
REQ-020 In LOAD, SHALL wrap col_cnt at IMG_COLS-1 to 0 and increment row_cnt on each wrap.
REQ-021 When pixel WIDTH*IMG_COLS-1 is accepted with pix_last=1, SHALL move to EMIT with k=0; strip_valid is high on the next cycle.
REQ-022 When pix_last=1 is accepted on any earlier pixel, SHALL pulse frame_err, clear the counters and stay in LOAD; the frame is discarded.
REQ-023 When the final-position pixel is accepted with pix_last=0, SHALL pulse frame_err, clear the counters and stay in LOAD; no strips are emitted.
REQ-024 In EMIT, SHALL drive pix_ready=0, strip_valid=1 and strip/strip_idx/strip_last from k.
REQ-025 In EMIT, strip, strip_idx and strip_last SHALL remain stable while strip_ready=0.
REQ-026 On handshake with k<NUM_STRIPS-1, SHALL increment k.
REQ-027 On handshake with k=NUM_STRIPS-1, SHALL return to LOAD with the counters cleared; pix_ready is high on the next cycle.
REQ-028 With strip_ready held high, SHALL emit one strip per cycle, so EMIT lasts exactly NUM_STRIPS cycles.
REQ-029 SHALL drive pix_ready from the FSM state only, never from pix_valid or strip_ready.

Reset
REQ-030 On rst=1, SHALL set the state to LOAD and clear row_cnt, col_cnt and k to 0.
REQ-031 During and after reset, strip_valid, frame_err, strip_idx and strip_last SHALL be 0 and strip SHALL be all-zero.
REQ-032 pix_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-033 SHALL abort any partial frame or EMIT sequence on reset; the frame store need not be cleared.

Structure
REQ-034 SHALL take WIDTH and LENGTH from global_params.vh.
REQ-035 SHALL place IMG_COLS, NUM_STRIPS and the FSM state enum in a shared package, strip_pkg.
REQ-036 SHALL implement the frame store plus column-slice mux as one sub-module, strip_frame_store (write port at (row, col); read port returns strip k).

Verification (WIDTH=28, LENGTH=4, IMG_COLS=28; 784 pixels per frame)
REQ-037 Bench SHALL send a frame with only column 5 set, strip_ready=1 -> strips 0..6 emitted; strip 1 has bit r*4+1 set for all r and every other bit 0; strip_last only on idx 6.
REQ-038 Bench SHALL hold strip_ready=0 for 10 cycles at k=3 -> strip, strip_idx=3 and strip_valid stay stable, and no strip is skipped afterwards.
REQ-039 Bench SHALL assert pix_last on pixel 100 -> frame_err pulses once and no strip_valid; the following correct frame emits all 7 strips.
REQ-040 Bench SHALL send pixel 783 with pix_last=0 -> frame_err pulses once, no strip_valid, and pix_ready stays 1.
REQ-041 Bench SHALL assert rst during EMIT at k=4 -> the next cycle has strip_valid=0 and pix_ready=1, and a fresh frame restarts at k=0.
REQ-042 Bench SHALL send back-to-back frames with pix_valid and strip_ready held high -> pix_ready is low for exactly 7 cycles between frames.
